// File: rtl/rgb_pattern_gen_pkg.sv
// ============================================================================
// rgb_pattern_gen_pkg : shared pattern indices and RGB565 colour constants
// Rev 1.0
// ============================================================================
`default_nettype none

package rgb_pattern_gen_pkg;

  typedef enum logic [1:0] {
    PAT_BARS = 2'd0,
    PAT_GRID = 2'd1,
    PAT_GRAD = 2'd2,
    PAT_BOX  = 2'd3
  } pattern_e;

  localparam logic [15:0] COLOR_WHITE   = 16'hFFFF;
  localparam logic [15:0] COLOR_YELLOW  = 16'hFFE0;
  localparam logic [15:0] COLOR_CYAN    = 16'h07FF;
  localparam logic [15:0] COLOR_GREEN   = 16'h07E0;
  localparam logic [15:0] COLOR_MAGENTA = 16'hF81F;
  localparam logic [15:0] COLOR_RED     = 16'hF800;
  localparam logic [15:0] COLOR_BLUE    = 16'h001F;
  localparam logic [15:0] COLOR_BLACK   = 16'h0000;

  function automatic logic [15:0] bar_color(input logic [2:0] bar);
    case (bar)
      3'd0:    return COLOR_WHITE;
      3'd1:    return COLOR_YELLOW;
      3'd2:    return COLOR_CYAN;
      3'd3:    return COLOR_GREEN;
      3'd4:    return COLOR_MAGENTA;
      3'd5:    return COLOR_RED;
      3'd6:    return COLOR_BLUE;
      default: return COLOR_BLACK;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/rgb_box_mover.sv
// ============================================================================
// rgb_box_mover : bouncing-box position, per-frame motion and pixel hit test
// Rev 1.0
// ============================================================================
`default_nettype none

module rgb_box_mover #(
  parameter int H_ACTIVE = 800,
  parameter int V_ACTIVE = 480,
  parameter int BOX_SIZE = 64,
  parameter int BOX_STEP = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fe,
  input  logic        enable,
  input  logic [10:0] x,
  input  logic [10:0] y,
  output logic        hit
);

  localparam logic [11:0] MAX_X = 12'(H_ACTIVE - BOX_SIZE);
  localparam logic [11:0] MAX_Y = 12'(V_ACTIVE - BOX_SIZE);
  localparam logic [11:0] STEP  = 12'(BOX_STEP);
  localparam logic [11:0] SIZE  = 12'(BOX_SIZE);

  logic [11:0] box_x;
  logic [11:0] box_y;
  logic        dir_x;
  logic        dir_y;
  logic [12:0] next_x;
  logic [12:0] next_y;
  logic [11:0] px;
  logic [11:0] py;

  // Returns {new_pos, new_dir}; dir 1 means moving towards larger coordinates.
  function automatic logic [12:0] step_axis(input logic [11:0] pos,
                                            input logic        dir,
                                            input logic [11:0] max);
    if (dir) begin
      if (pos + STEP > max) return {max, 1'b0};
      else                  return {pos + STEP, 1'b1};
    end else begin
      if (pos < STEP)       return {12'd0, 1'b1};
      else                  return {pos - STEP, 1'b0};
    end
  endfunction

  assign next_x = step_axis(box_x, dir_x, MAX_X);
  assign next_y = step_axis(box_y, dir_y, MAX_Y);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      box_x <= '0;
      box_y <= '0;
      dir_x <= 1'b1;
      dir_y <= 1'b1;
    end else if (fe && enable) begin
      {box_x, dir_x} <= next_x;
      {box_y, dir_y} <= next_y;
    end
  end

  assign px  = {1'b0, x};
  assign py  = {1'b0, y};
  assign hit = (px >= box_x) && (px < box_x + SIZE) &&
               (py >= box_y) && (py < box_y + SIZE);

endmodule

`default_nettype wire

// File: rtl/rgb_pattern_gen.sv
// ============================================================================
// rgb_pattern_gen : 2-stage RGB565 test-pattern source with frame-aligned switching
// Rev 1.0
// ============================================================================
`default_nettype none

module rgb_pattern_gen
  import rgb_pattern_gen_pkg::*;
#(
  parameter int H_ACTIVE    = 800,
  parameter int V_ACTIVE    = 480,
  parameter int VS_POL      = 0,
  parameter int AUTO_FRAMES = 120,
  parameter int BOX_SIZE    = 64,
  parameter int BOX_STEP    = 4
) (
  input  logic        rgb_clk,
  input  logic        rgb_rst,
  input  logic        rgb_hs_i,
  input  logic        rgb_vs_i,
  input  logic        rgb_de_i,
  input  logic [10:0] rgb_x,
  input  logic [10:0] rgb_y,
  input  logic        auto_en,
  input  logic        next_pulse,
  output logic        rgb_hs,
  output logic        rgb_vs,
  output logic        rgb_de,
  output logic [4:0]  rgb_r,
  output logic [5:0]  rgb_g,
  output logic [4:0]  rgb_b,
  output logic [1:0]  pattern
);

  localparam logic       VS_LVL    = (VS_POL != 0);
  localparam logic [7:0] AUTO_LAST = 8'(AUTO_FRAMES - 1);

  pattern_e    pattern_q;
  logic [7:0]  frame_cnt;
  logic        pending;
  logic        fe;
  logic        auto_adv;

  logic        hs_d1;
  logic        vs_d1;
  logic        de_d1;
  logic [2:0]  bar_d1;
  logic        grid_d1;
  logic        box_d1;
  logic [4:0]  grad_r_d1;
  logic [5:0]  grad_g_d1;

  logic [2:0]  bar;
  logic        grid_hit;
  logic        box_hit;
  logic [15:0] color;

  // vs_d1 doubles as the registered copy of vsync used for edge detection.
  assign fe       = (vs_d1 != VS_LVL) && (rgb_vs_i == VS_LVL);
  assign auto_adv = auto_en && fe && (frame_cnt == AUTO_LAST);

  always_ff @(posedge rgb_clk or posedge rgb_rst) begin
    if (rgb_rst) begin
      pattern_q <= PAT_BARS;
      frame_cnt <= '0;
      pending   <= 1'b0;
    end else begin
      if (!auto_en)
        frame_cnt <= '0;
      else if (fe)
        frame_cnt <= auto_adv ? 8'd0 : frame_cnt + 8'd1;

      if (fe) begin
        if (pending || next_pulse || auto_adv)
          pattern_q <= pattern_e'(pattern_q + 2'd1);
        pending <= 1'b0;
      end else if (next_pulse) begin
        pending <= 1'b1;
      end
    end
  end

  assign pattern = pattern_q;

  rgb_box_mover #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .BOX_SIZE (BOX_SIZE),
    .BOX_STEP (BOX_STEP)
  ) u_box (
    .clk    (rgb_clk),
    .rst    (rgb_rst),
    .fe     (fe),
    .enable (pattern_q == PAT_BOX),
    .x      (rgb_x),
    .y      (rgb_y),
    .hit    (box_hit)
  );

  // Bar index by threshold counting: each 100-pixel boundary passed adds one.
  always_comb begin
    bar = 3'd0;
    for (int i = 1; i < 8; i++)
      if (rgb_x >= 11'(i * 100)) bar = 3'(i);
  end

  assign grid_hit = (rgb_x[4:0] == 5'd0) || (rgb_y[4:0] == 5'd0) ||
                    (rgb_x == 11'(H_ACTIVE - 1)) || (rgb_y == 11'(V_ACTIVE - 1));

  always_ff @(posedge rgb_clk or posedge rgb_rst) begin
    if (rgb_rst) begin
      hs_d1     <= 1'b0;
      vs_d1     <= 1'b0;
      de_d1     <= 1'b0;
      bar_d1    <= '0;
      grid_d1   <= 1'b0;
      box_d1    <= 1'b0;
      grad_r_d1 <= '0;
      grad_g_d1 <= '0;
    end else begin
      hs_d1     <= rgb_hs_i;
      vs_d1     <= rgb_vs_i;
      de_d1     <= rgb_de_i;
      bar_d1    <= bar;
      grid_d1   <= grid_hit;
      box_d1    <= box_hit;
      grad_r_d1 <= rgb_x[9:5];
      grad_g_d1 <= rgb_y[8:3];
    end
  end

  always_comb begin
    color = COLOR_BLACK;
    case (pattern_q)
      PAT_BARS: color = bar_color(bar_d1);
      PAT_GRID: color = grid_d1 ? COLOR_WHITE : COLOR_BLACK;
      PAT_GRAD: color = {grad_r_d1, grad_g_d1, 5'd31 - grad_r_d1};
      PAT_BOX:  color = box_d1 ? COLOR_RED : COLOR_BLUE;
      default:  color = COLOR_BLACK;
    endcase
    if (!de_d1) color = COLOR_BLACK;
  end

  always_ff @(posedge rgb_clk or posedge rgb_rst) begin
    if (rgb_rst) begin
      rgb_hs <= 1'b0;
      rgb_vs <= 1'b0;
      rgb_de <= 1'b0;
      rgb_r  <= '0;
      rgb_g  <= '0;
      rgb_b  <= '0;
    end else begin
      rgb_hs <= hs_d1;
      rgb_vs <= vs_d1;
      rgb_de <= de_d1;
      rgb_r  <= color[15:11];
      rgb_g  <= color[10:5];
      rgb_b  <= color[4:0];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rgb_pattern_gen.sv
// ============================================================================
// tb_rgb_pattern_gen : bench for rgb_pattern_gen with a frame-level reference model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_rgb_pattern_gen;

  localparam int AF   = 3;
  localparam int HA   = 800;
  localparam int VA   = 480;
  localparam int BOX  = 64;
  localparam int STEP = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        hs_i = 1'b0;
  logic        vs_i = 1'b1;
  logic        de_i = 1'b0;
  logic [10:0] x_i = '0;
  logic [10:0] y_i = '0;
  logic        auto_en = 1'b0;
  logic        next_pulse = 1'b0;
  logic        rgb_hs, rgb_vs, rgb_de;
  logic [4:0]  rgb_r;
  logic [5:0]  rgb_g;
  logic [4:0]  rgb_b;
  logic [1:0]  pattern;

  always #5 clk = ~clk;

  rgb_pattern_gen #(
    .H_ACTIVE (HA), .V_ACTIVE (VA), .VS_POL (0),
    .AUTO_FRAMES (AF), .BOX_SIZE (BOX), .BOX_STEP (STEP)
  ) dut (
    .rgb_clk (clk), .rgb_rst (rst),
    .rgb_hs_i (hs_i), .rgb_vs_i (vs_i), .rgb_de_i (de_i),
    .rgb_x (x_i), .rgb_y (y_i),
    .auto_en (auto_en), .next_pulse (next_pulse),
    .rgb_hs (rgb_hs), .rgb_vs (rgb_vs), .rgb_de (rgb_de),
    .rgb_r (rgb_r), .rgb_g (rgb_g), .rgb_b (rgb_b),
    .pattern (pattern)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state: frame-level view of pattern control and the box.
  int          m_pat, m_pend, m_cnt, m_bx, m_by, m_dx, m_dy;
  logic        m_prev_vs;
  logic [18:0] exp_q;
  logic [15:0] bar_tab [8];

  typedef struct {
    int          pat;
    int          x;
    int          y;
    logic        de;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [22];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] exp_color(input int x, input int y);
    int r;
    case (m_pat)
      0: return bar_tab[x / 100];
      1: return ((x % 32 == 0) || (y % 32 == 0) || (x == HA - 1) || (y == VA - 1)) ? 16'hFFFF : 16'h0000;
      2: begin
        r = (x / 32) % 32;
        return {5'(r), 6'((y / 8) % 64), 5'(31 - r)};
      end
      default: return (x >= m_bx && x < m_bx + BOX && y >= m_by && y < m_by + BOX) ? 16'hF800 : 16'h001F;
    endcase
  endfunction

  task automatic move_axis(inout int p, inout int d, input int mx);
    if (d > 0) begin
      if (p + STEP > mx) begin p = mx; d = -1; end
      else p = p + STEP;
    end else begin
      if (p < STEP) begin p = 0; d = 1; end
      else p = p - STEP;
    end
  endtask

  task automatic model_step(input logic vs, input logic np, input logic ae);
    logic fe, adv;
    fe  = (m_prev_vs != 1'b0) && (vs == 1'b0);
    adv = 1'b0;
    if (!ae) m_cnt = 0;
    else if (fe) begin
      if (m_cnt == AF - 1) begin m_cnt = 0; adv = 1'b1; end
      else m_cnt++;
    end
    if (fe) begin
      if (m_pat == 3) begin
        move_axis(m_bx, m_dx, HA - BOX);
        move_axis(m_by, m_dy, VA - BOX);
      end
      if (m_pend != 0 || np || adv) m_pat = (m_pat + 1) % 4;
      m_pend = 0;
    end else if (np) m_pend = 1;
    m_prev_vs = vs;
  endtask

  task automatic model_reset();
    m_pat = 0; m_pend = 0; m_cnt = 0;
    m_bx = 0; m_by = 0; m_dx = 1; m_dy = 1;
    m_prev_vs = 1'b0;
    exp_q = '0;
  endtask

  // One clock: model predicts this cycle's output (seen one edge later), then the edge.
  task automatic cycle();
    logic [18:0] now_exp, cur;
    cur = {hs_i, vs_i, de_i, de_i ? exp_color(int'(x_i), int'(y_i)) : 16'h0000};
    now_exp = exp_q;
    exp_q = cur;
    model_step(vs_i, next_pulse, auto_en);
    @(posedge clk); #1;
    check("pipe", {13'd0, rgb_hs, rgb_vs, rgb_de, rgb_r, rgb_g, rgb_b}, {13'd0, now_exp});
    check("pattern", {30'd0, pattern}, 32'(m_pat));
  endtask

  task automatic drive(input logic hs, input logic vs, input logic de,
                       input int x, input int y, input logic np);
    hs_i = hs; vs_i = vs; de_i = de;
    x_i = 11'(x); y_i = 11'(y); next_pulse = np;
    cycle();
    next_pulse = 1'b0;
  endtask

  task automatic idle();
    drive(1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
  endtask

  // Sync window: the first active-level cycle is the frame event; DE stays low around it.
  task automatic vsync(input logic np_at_fe);
    drive(1'b0, 1'b0, 1'b0, 0, 0, np_at_fe);
    drive(1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    idle();
    idle();
  endtask

  task automatic pix(input int x, input int y, input logic de, input logic np);
    drive(1'($urandom_range(0, 1)), 1'b1, de, x, y, np);
  endtask

  task automatic probe(input string name, input int x, input int y,
                       input logic de, input logic [15:0] exp);
    pix(x, y, de, 1'b0);
    idle();
    check(name, {16'd0, rgb_r, rgb_g, rgb_b}, {16'd0, exp});
  endtask

  task automatic go_pattern(input int p);
    for (int k = 0; k < 4; k++)
      if (m_pat != p) begin
        pix(10, 10, 1'b1, 1'b1);
        vsync(1'b0);
      end
  endtask

  task automatic do_reset();
    #1 rst = 1'b1;
    hs_i = 1'b0; vs_i = 1'b1; de_i = 1'b0; next_pulse = 1'b0;
    #1;
    check("rst_async", {18'd0, rgb_hs, rgb_vs, rgb_de, rgb_r, rgb_g, rgb_b, pattern}, 32'd0);
    @(posedge clk); #1;
    check("rst_hold", {18'd0, rgb_hs, rgb_vs, rgb_de, rgb_r, rgb_g, rgb_b, pattern}, 32'd0);
    #2 rst = 1'b0;
    model_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bar_tab = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
    vecs = '{
      '{0,   0,   0, 1'b1, 16'hFFFF}, '{0,  99,   0, 1'b1, 16'hFFFF},
      '{0, 100,   0, 1'b1, 16'hFFE0}, '{0, 250,   3, 1'b1, 16'h07FF},
      '{0, 399,   3, 1'b1, 16'h07E0}, '{0, 400,   3, 1'b1, 16'hF81F},
      '{0, 599,   3, 1'b1, 16'hF800}, '{0, 600,   3, 1'b1, 16'h001F},
      '{0, 700,   3, 1'b1, 16'h0000}, '{0, 799,   3, 1'b1, 16'h0000},
      '{0,  50,  50, 1'b0, 16'h0000},
      '{1,  32,   5, 1'b1, 16'hFFFF}, '{1,  33,   5, 1'b1, 16'h0000},
      '{1, 799,   7, 1'b1, 16'hFFFF}, '{1,  33, 479, 1'b1, 16'hFFFF},
      '{1,  33,  64, 1'b1, 16'hFFFF}, '{1, 798, 478, 1'b1, 16'h0000},
      '{2,   0,   0, 1'b1, 16'h001F}, '{2,  32,   8, 1'b1, 16'h083E},
      '{2, 799, 479, 1'b1, 16'hC767}, '{2, 400, 200, 1'b1, 16'h6333},
      '{2, 400, 200, 1'b0, 16'h0000}
    };

    do_reset();

    // One full active line of colour bars.
    vsync(1'b0);
    for (int x = 0; x < HA; x++) pix(x, 10, 1'b1, 1'b0);
    idle();
    idle();

    for (int i = 0; i < 22; i++) begin
      if (vecs[i].pat == 1 && m_pat == 0) begin
        // Two requests within one frame collapse into a single advance.
        pix(200, 20, 1'b1, 1'b1);
        pix(201, 20, 1'b1, 1'b0);
        pix(202, 20, 1'b1, 1'b1);
        idle();
        check("req_hold", {30'd0, pattern}, 32'd0);
        vsync(1'b0);
        check("req_once", {30'd0, pattern}, 32'd1);
      end
      go_pattern(vecs[i].pat);
      probe($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].de, vecs[i].exp);
    end

    // Bouncing box over 200 frames.
    go_pattern(3);
    for (int f = 0; f < 200; f++) begin
      vsync(1'b0);
      probe("box_in", m_bx, m_by, 1'b1, 16'hF800);
      probe("box_corner", m_bx + BOX - 1, m_by + BOX - 1, 1'b1, 16'hF800);
      if (m_bx + BOX < HA) probe("box_right", m_bx + BOX, m_by, 1'b1, 16'h001F);
      if (m_by + BOX < VA) probe("box_below", m_bx, m_by + BOX, 1'b1, 16'h001F);
      if (m_bx > 0) probe("box_left", m_bx - 1, m_by, 1'b1, 16'h001F);
    end

    // Reset in the middle of an active line while showing the box.
    pix(120, 40, 1'b1, 1'b0);
    pix(121, 40, 1'b1, 1'b0);
    do_reset();
    check("rst_pat", {30'd0, pattern}, 32'd0);
    go_pattern(3);
    probe("rst_box00", 0, 0, 1'b1, 16'hF800);
    probe("rst_box63", 63, 63, 1'b1, 16'hF800);
    probe("rst_box64x", 64, 0, 1'b1, 16'h001F);
    probe("rst_box64y", 0, 64, 1'b1, 16'h001F);

    // Automatic cycling, with a manual request landing on an advance frame.
    do_reset();
    auto_en = 1'b1;
    idle();
    for (int k = 1; k <= 18; k++) begin
      if (k == 15) pix(300, 30, 1'b1, 1'b1);
      vsync(k == 15);
      pix($urandom_range(0, HA - 1), $urandom_range(0, VA - 1), 1'b1, 1'b0);
      check("auto_pat", {30'd0, pattern}, 32'((k / AF) % 4));
    end

    // Randomized frames against the reference model.
    for (int f = 0; f < 40; f++) begin
      auto_en = 1'($urandom_range(0, 1));
      idle();
      vsync($urandom_range(0, 3) == 0);
      for (int p = 0; p < 20; p++)
        pix($urandom_range(0, HA - 1), $urandom_range(0, VA - 1),
            1'($urandom_range(0, 3) != 0), $urandom_range(0, 7) == 0);
      idle();
    end
    idle();
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
